// File: rtl/data_memory_pkg.sv
// rtl/data_memory_pkg.sv - shared state encoding and read-during-write policy constants
package data_memory_pkg;

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_RUN   = 1'b1
  } state_e;

  localparam int RDW_WRITE_FIRST = 0;
  localparam int RDW_READ_FIRST  = 1;

endpackage

// File: rtl/data_memory_clear_fsm.sv
// rtl/data_memory_clear_fsm.sv - clear sequencer: walks every address writing zero, then raises ready
module data_memory_clear_fsm
  import data_memory_pkg::*;
#(
  parameter int ADDR_WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  clear,
  output logic                  ready,
  output logic                  clr_we,
  output logic [ADDR_WIDTH-1:0] clr_addr
);

  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = '1;

  state_e                state_q;
  logic [ADDR_WIDTH-1:0] cnt_q;
  logic                  ready_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_CLEAR;
      cnt_q   <= '0;
      ready_q <= 1'b0;
    end else begin
      case (state_q)
        ST_CLEAR: begin
          // A new clear request restarts the sweep even if it was nearly done
          if (clear) begin
            cnt_q <= '0;
          end else if (cnt_q == LAST_ADDR) begin
            state_q <= ST_RUN;
            ready_q <= 1'b1;
            cnt_q   <= '0;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        ST_RUN: begin
          if (clear) begin
            state_q <= ST_CLEAR;
            cnt_q   <= '0;
            ready_q <= 1'b0;
          end
        end
        default: begin
          state_q <= ST_CLEAR;
          cnt_q   <= '0;
          ready_q <= 1'b0;
        end
      endcase
    end
  end

  assign ready    = ready_q;
  assign clr_we   = (state_q == ST_CLEAR);
  assign clr_addr = cnt_q;

endmodule

// File: rtl/data_memory_sync.sv
// rtl/data_memory_sync.sv - clocked data memory with registered read port and hardware clear
module data_memory_sync
  import data_memory_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4,
  parameter int RDW_MODE   = 0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  clear,
  output logic                  ready,
  input  logic                  write_en,
  input  logic [ADDR_WIDTH-1:0] write_select,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  read_en,
  input  logic [ADDR_WIDTH-1:0] read_select,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  data_valid
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic                  clr_we;
  logic [ADDR_WIDTH-1:0] clr_addr;
  logic                  user_ok;
  logic [DATA_WIDTH-1:0] data_out_d, data_out_q;
  logic                  data_valid_d, data_valid_q;

  data_memory_clear_fsm #(
    .ADDR_WIDTH(ADDR_WIDTH)
  ) u_clear_fsm (
    .clk     (clk),
    .rst_n   (rst_n),
    .clear   (clear),
    .ready   (ready),
    .clr_we  (clr_we),
    .clr_addr(clr_addr)
  );

  // User accesses only count in RUN, and a clear request drops them
  assign user_ok = ready & ~clear;

  always_ff @(posedge clk) begin
    if (clr_we) begin
      mem_q[clr_addr] <= '0;
    end else if (user_ok && write_en) begin
      mem_q[write_select] <= data_in;
    end
  end

  always_comb begin
    data_out_d   = data_out_q;
    data_valid_d = 1'b0;
    if (user_ok && read_en) begin
      data_valid_d = 1'b1;
      data_out_d   = mem_q[read_select];
      if (RDW_MODE == RDW_WRITE_FIRST && write_en && write_select == read_select) begin
        data_out_d = data_in;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_out_q   <= '0;
      data_valid_q <= 1'b0;
    end else begin
      data_out_q   <= data_out_d;
      data_valid_q <= data_valid_d;
    end
  end

  assign data_out   = data_out_q;
  assign data_valid = data_valid_q;

endmodule

// File: tb/tb_data_memory_sync.sv
// tb/tb_data_memory_sync.sv - self-checking bench for data_memory_sync in both read-during-write modes
module tb_data_memory_sync;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       clear;
  logic       write_en;
  logic [3:0] write_select;
  logic [7:0] data_in;
  logic       read_en;
  logic [3:0] read_select;
  logic       ready0, ready1;
  logic [7:0] dout0, dout1;
  logic       valid0, valid1;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  data_memory_sync #(.DATA_WIDTH(8), .ADDR_WIDTH(4), .RDW_MODE(0)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .clear(clear), .ready(ready0),
    .write_en(write_en), .write_select(write_select), .data_in(data_in),
    .read_en(read_en), .read_select(read_select),
    .data_out(dout0), .data_valid(valid0)
  );

  data_memory_sync #(.DATA_WIDTH(8), .ADDR_WIDTH(4), .RDW_MODE(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .clear(clear), .ready(ready1),
    .write_en(write_en), .write_select(write_select), .data_in(data_in),
    .read_en(read_en), .read_select(read_select),
    .data_out(dout1), .data_valid(valid1)
  );

  // Reference model: memory contents plus a count of edges left before ready
  logic [7:0] mem_m [16];
  int         busy_m;
  logic       ready_m, valid_m;
  logic [7:0] dout0_m, dout1_m;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  task automatic model_reset();
    foreach (mem_m[i]) mem_m[i] = 8'h00;
    busy_m  = 16;
    ready_m = 1'b0;
    valid_m = 1'b0;
    dout0_m = 8'h00;
    dout1_m = 8'h00;
  endtask

  task automatic model_edge();
    logic [7:0] old;
    if (!ready_m) begin
      valid_m = 1'b0;
      if (clear) busy_m = 16;
      else begin
        busy_m--;
        if (busy_m == 0) ready_m = 1'b1;
      end
    end else if (clear) begin
      foreach (mem_m[i]) mem_m[i] = 8'h00;
      busy_m  = 16;
      ready_m = 1'b0;
      valid_m = 1'b0;
    end else begin
      old = mem_m[read_select];
      valid_m = read_en;
      if (read_en) begin
        dout0_m = (write_en && write_select == read_select) ? data_in : old;
        dout1_m = old;
      end
      if (write_en) mem_m[write_select] = data_in;
    end
  endtask

  task automatic compare_model();
    chk("model_ready0", ready0, ready_m);
    chk("model_ready1", ready1, ready_m);
    chk("model_valid0", valid0, valid_m);
    chk("model_valid1", valid1, valid_m);
    chk("model_dout0", dout0, dout0_m);
    chk("model_dout1", dout1, dout1_m);
  endtask

  task automatic step(input logic we, input logic [3:0] ws, input logic [7:0] din,
                      input logic re, input logic [3:0] rs, input logic clr);
    write_en = we; write_select = ws; data_in = din;
    read_en = re; read_select = rs; clear = clr;
    @(posedge clk);
    model_edge();
    #1;
    compare_model();
  endtask

  task automatic idle();
    step(1'b0, 4'h0, 8'h00, 1'b0, 4'h0, 1'b0);
  endtask

  task automatic wait_ready(output int n);
    n = 0;
    do begin
      idle();
      n++;
    end while (!ready0 && n < 40);
  endtask

  typedef struct {
    logic       we;
    logic [3:0] ws;
    logic [7:0] din;
    logic       re;
    logic [3:0] rs;
    logic [7:0] exp0;
    logic [7:0] exp1;
    logic       exp_v;
  } vec_t;

  vec_t tbl[13];

  function automatic vec_t mk(logic we, logic [3:0] ws, logic [7:0] din, logic re,
                              logic [3:0] rs, logic [7:0] e0, logic [7:0] e1, logic ev);
    vec_t v;
    v.we = we; v.ws = ws; v.din = din; v.re = re; v.rs = rs;
    v.exp0 = e0; v.exp1 = e1; v.exp_v = ev;
    return v;
  endfunction

  initial begin
    int n;
    tbl[0]  = mk(1, 4'd0,  8'hAA, 0, 4'd0,  8'h00, 8'h00, 0);
    tbl[1]  = mk(1, 4'd7,  8'h55, 0, 4'd0,  8'h00, 8'h00, 0);
    tbl[2]  = mk(1, 4'd15, 8'hFF, 0, 4'd0,  8'h00, 8'h00, 0);
    tbl[3]  = mk(0, 4'd0,  8'h00, 1, 4'd0,  8'hAA, 8'hAA, 1);
    tbl[4]  = mk(0, 4'd0,  8'h00, 1, 4'd7,  8'h55, 8'h55, 1);
    tbl[5]  = mk(0, 4'd0,  8'h00, 1, 4'd15, 8'hFF, 8'hFF, 1);
    tbl[6]  = mk(0, 4'd0,  8'h00, 0, 4'd0,  8'hFF, 8'hFF, 0);
    tbl[7]  = mk(1, 4'd5,  8'h12, 0, 4'd0,  8'hFF, 8'hFF, 0);
    tbl[8]  = mk(1, 4'd5,  8'h3C, 1, 4'd5,  8'h3C, 8'h12, 1);
    tbl[9]  = mk(0, 4'd0,  8'h00, 1, 4'd5,  8'h3C, 8'h3C, 1);
    tbl[10] = mk(1, 4'd10, 8'h1A, 0, 4'd0,  8'h3C, 8'h3C, 0);
    tbl[11] = mk(0, 4'd10, 8'hCC, 1, 4'd10, 8'h1A, 8'h1A, 1);
    tbl[12] = mk(0, 4'd0,  8'h00, 1, 4'd10, 8'h1A, 8'h1A, 1);

    rst_n = 1'b0; clear = 1'b0; write_en = 1'b0; write_select = 4'h0;
    data_in = 8'h00; read_en = 1'b0; read_select = 4'h0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("reset_ready", ready0, 1'b0);
    chk("reset_valid", valid0, 1'b0);
    chk("reset_dout", dout0, 8'h00);

    // Release reset: ready must rise on exactly the 16th edge
    rst_n = 1'b1;
    wait_ready(n);
    chk("ready_edges_after_reset", n, 16);
    for (int a = 0; a < 16; a++) begin
      step(1'b0, 4'h0, 8'h00, 1'b1, a[3:0], 1'b0);
      chk("cleared_read_valid", valid0, 1'b1);
      chk("cleared_read_data", dout0, 8'h00);
    end

    foreach (tbl[i]) begin
      step(tbl[i].we, tbl[i].ws, tbl[i].din, tbl[i].re, tbl[i].rs, 1'b0);
      chk($sformatf("tbl%0d_dout0", i), dout0, tbl[i].exp0);
      chk($sformatf("tbl%0d_dout1", i), dout1, tbl[i].exp1);
      chk($sformatf("tbl%0d_valid", i), valid0, tbl[i].exp_v);
    end

    // Clear wins over a simultaneous write and read
    step(1'b1, 4'd2, 8'h77, 1'b0, 4'd0, 1'b0);
    step(1'b1, 4'd9, 8'h99, 1'b0, 4'd0, 1'b0);
    step(1'b1, 4'd2, 8'h44, 1'b1, 4'd9, 1'b1);
    chk("clear_ready_low", ready0, 1'b0);
    chk("clear_valid_low", valid0, 1'b0);
    wait_ready(n);
    chk("ready_edges_after_clear", n, 16);
    step(1'b0, 4'h0, 8'h00, 1'b1, 4'd2, 1'b0);
    chk("clear_addr2", dout0, 8'h00);
    step(1'b0, 4'h0, 8'h00, 1'b1, 4'd9, 1'b0);
    chk("clear_addr9", dout0, 8'h00);

    // Reset in the middle of a clear sweep restarts the whole sequence
    step(1'b1, 4'd3, 8'h5A, 1'b0, 4'd0, 1'b0);
    step(1'b0, 4'h0, 8'h00, 1'b1, 4'd3, 1'b0);
    chk("pre_reset_dout", dout0, 8'h5A);
    step(1'b0, 4'h0, 8'h00, 1'b0, 4'd0, 1'b1);
    repeat (8) idle();
    rst_n = 1'b0;
    #1;
    model_reset();
    chk("midclear_reset_ready", ready0, 1'b0);
    chk("midclear_reset_valid", valid0, 1'b0);
    chk("midclear_reset_dout0", dout0, 8'h00);
    chk("midclear_reset_dout1", dout1, 8'h00);
    rst_n = 1'b1;
    wait_ready(n);
    chk("ready_edges_after_midclear_reset", n, 16);

    // Randomized traffic against the model, with occasional clears
    for (int k = 0; k < 400; k++) begin
      logic [3:0] ws, rs;
      ws = 4'($urandom_range(0, 15));
      rs = ($urandom_range(0, 2) == 0) ? ws : 4'($urandom_range(0, 15));
      step(1'($urandom_range(0, 1)), ws, 8'($urandom), 1'($urandom_range(0, 1)), rs,
           ($urandom_range(0, 39) == 0));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
